// File: rtl/axis_arb_pkg.sv
// axis_arb_pkg: shared FSM state type and round-robin winner search for the packet arbiter.
package axis_arb_pkg;

    typedef enum logic {IDLE, LOCKED} arb_state_t;

    localparam int MAX_INPUTS = 16;

    // Scan from last+1 upward with wrap-around; the lowest offset that is valid wins.
    function automatic logic [3:0] rr_next(input logic [MAX_INPUTS-1:0] valid, input logic [3:0] last, input int n);
        logic [3:0] w;
        logic [3:0] idx;
        w = last;
        for (int k = MAX_INPUTS; k >= 1; k--) begin
            idx = 4'((int'(last) + k) % n);
            if (k <= n && valid[idx]) w = idx;
        end
        return w;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// axis_rr_pick: combinational rotate-and-priority-encode picking the next round-robin winner.
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]         valid_i,
    input  logic [$clog2(N)-1:0] ptr_i,
    output logic [$clog2(N)-1:0] win_o,
    output logic                 any_o
);
    localparam int W = $clog2(N);

    logic [3:0] w;

    assign w     = rr_next(MAX_INPUTS'(valid_i), 4'(ptr_i), N);
    assign win_o = W'(w);
    assign any_o = |valid_i;

endmodule

// File: rtl/axis_rr_packet_arbiter.sv
// axis_rr_packet_arbiter: packet-locked round-robin merge of NUM_INPUTS AXI-Stream inputs into one
// registered output. Define AXIS_ARB_TID_EN to add M_AXIS_TID carrying the source index of each beat.
module axis_rr_packet_arbiter
    import axis_arb_pkg::*;
#(
    parameter int TDATA_WIDTH = 224,
    parameter int NUM_INPUTS  = 4
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [NUM_INPUTS*TDATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [NUM_INPUTS-1:0]             S_AXIS_TVALID,
    input  logic [NUM_INPUTS-1:0]             S_AXIS_TLAST,
    output logic [NUM_INPUTS-1:0]             S_AXIS_TREADY,
    output logic [TDATA_WIDTH-1:0]            M_AXIS_TDATA,
    output logic                              M_AXIS_TVALID,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY,
    output logic [$clog2(NUM_INPUTS)-1:0]     GRANT
`ifdef AXIS_ARB_TID_EN
    ,
    output logic [$clog2(NUM_INPUTS)-1:0]     M_AXIS_TID
`endif
);
    localparam int GW = $clog2(NUM_INPUTS);

    arb_state_t             state_q;
    logic [GW-1:0]          grant_q;
    logic [GW-1:0]          win;
    logic                   any_valid;
    logic                   ready;
    logic                   accept;
    logic                   sel_last;
    logic [TDATA_WIDTH-1:0] sel_data;
    logic [TDATA_WIDTH-1:0] tdata_q;
    logic                   tvalid_q;
    logic                   tlast_q;
`ifdef AXIS_ARB_TID_EN
    logic [GW-1:0]          tid_q;
`endif

    axis_rr_pick #(.N(NUM_INPUTS)) u_pick (
        .valid_i (S_AXIS_TVALID),
        .ptr_i   (grant_q),
        .win_o   (win),
        .any_o   (any_valid)
    );

    // The output slice can take a beat whenever it is empty or being drained this cycle.
    assign ready         = state_q == LOCKED && (!tvalid_q || M_AXIS_TREADY);
    assign sel_data      = S_AXIS_TDATA[grant_q*TDATA_WIDTH +: TDATA_WIDTH];
    assign sel_last      = S_AXIS_TLAST[grant_q];
    assign accept        = ready && S_AXIS_TVALID[grant_q];
    assign S_AXIS_TREADY = ready ? (NUM_INPUTS'(1) << grant_q) : '0;
    assign M_AXIS_TDATA  = tdata_q;
    assign M_AXIS_TVALID = tvalid_q;
    assign M_AXIS_TLAST  = tlast_q;
    assign GRANT         = grant_q;
`ifdef AXIS_ARB_TID_EN
    assign M_AXIS_TID    = tid_q;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= IDLE;
            grant_q  <= GW'(NUM_INPUTS - 1);
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tdata_q  <= '0;
`ifdef AXIS_ARB_TID_EN
            tid_q    <= '0;
`endif
        end else begin
            if (state_q == IDLE) begin
                if (any_valid) begin
                    grant_q <= win;
                    state_q <= LOCKED;
                end
            end else if (accept && sel_last) begin
                state_q <= IDLE;
            end
            if (accept) begin
                tdata_q  <= sel_data;
                tlast_q  <= sel_last;
                tvalid_q <= 1'b1;
`ifdef AXIS_ARB_TID_EN
                tid_q    <= grant_q;
`endif
            end else if (M_AXIS_TREADY) begin
                tvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/axis_rr_packet_arbiter.md
# axis_rr_packet_arbiter

Shares one AXI-Stream master output between NUM_INPUTS packet-framed AXI-Stream slave inputs on a single clock domain. Grants are round-robin and locked for a whole packet, so beats from different sources never interleave. A one-deep registered output slice decouples timing. The block sits upstream of the stream clock-domain crossing, merging several producers into one stream before it leaves the clock domain.

## Interface
- TDATA_WIDTH, 224: data width per beat.
- NUM_INPUTS, 4: number of slave inputs; legal range 2..16.
- CLK  in  1  the only clock; all logic is on its rising edge.
- RST  in  1  asynchronous, active-high reset.
- S_AXIS_TDATA  in  NUM_INPUTS*TDATA_WIDTH  input i occupies bits [i*TDATA_WIDTH +: TDATA_WIDTH].
- S_AXIS_TVALID  in  NUM_INPUTS  per-input valid.
- S_AXIS_TLAST  in  NUM_INPUTS  per-input end-of-packet.
- S_AXIS_TREADY  out  NUM_INPUTS  per-input ready.
- M_AXIS_TDATA  out  TDATA_WIDTH  registered output data.
- M_AXIS_TVALID  out  1  registered output valid.
- M_AXIS_TLAST  out  1  registered output end-of-packet.
- M_AXIS_TREADY  in  1  downstream ready.
- GRANT  out  $clog2(NUM_INPUTS)  index of the input currently or last granted.
- Clocking and reset, as decided: one clock, CLK; reset RST is asynchronous and active-high.

## Operation
- The FSM has two states: IDLE and LOCKED.
- IDLE:
  - All S_AXIS_TREADY are 0.
  - If any S_AXIS_TVALID bit is 1, select the first valid input found by scanning from (GRANT+1) mod NUM_INPUTS upward with wrap-around.
  - Load the selection into GRANT and move to LOCKED.
  - If no input is valid, stay in IDLE.
- LOCKED:
  - S_AXIS_TREADY[GRANT] = !M_AXIS_TVALID || M_AXIS_TREADY. All other ready bits are 0.
  - A slave beat is accepted when TVALID and TREADY are both 1 on the granted input. An accepted beat loads TDATA and TLAST into the output register and sets M_AXIS_TVALID.
  - An accepted beat with TLAST=1 returns the FSM to IDLE. GRANT holds its value; it is the round-robin pointer.
- Output slice:
  - M_AXIS_TVALID clears when the output beat is taken (M_AXIS_TVALID && M_AXIS_TREADY) and no new beat is accepted in the same cycle.
  - While M_AXIS_TVALID=1 and M_AXIS_TREADY=0, TDATA, TVALID and TLAST hold stable.
- The granted source may deassert TVALID mid-packet. The grant stays locked; there is no timeout.
- A single-beat packet (TLAST on the first beat) is legal. It unlocks after that beat.
- Non-granted inputs must hold their data per AXI-Stream rules; the arbiter never drops a beat.

## Timing
- Reset values:
  - FSM state: IDLE.
  - GRANT: NUM_INPUTS-1, so input 0 wins the first arbitration.
  - M_AXIS_TVALID, M_AXIS_TLAST, M_AXIS_TDATA: all 0.
  - S_AXIS_TREADY: all 0.
- Arbitration costs one cycle: TVALID seen in IDLE at cycle n gives TREADY high at n+1.
- Slave-to-master latency: 1 cycle. A beat accepted at edge n appears on M_AXIS at n+1.
- Throughput: one beat per cycle within a packet.
- Between packets there is one idle cycle on the slave side, because the FSM passes through IDLE.
- Output TLAST taken and a new slave beat accepted in the same cycle: the register reloads and TVALID stays 1.
- Reset asserted mid-packet: everything clears immediately and asynchronously. The partial packet is lost downstream. Upstream is responsible for re-framing.

## Configuration
- AXIS_ARB_TID_EN defined:
  - Adds output port M_AXIS_TID, $clog2(NUM_INPUTS) bits wide.
  - It is registered alongside TDATA and holds the GRANT value of the beat in the output register. Reset value 0.
- AXIS_ARB_TID_EN undefined: the port does not exist, and the source identity is carried only by GRANT.

## Structure
- Package axis_arb_pkg holds:
  - typedef arb_state_t (IDLE, LOCKED);
  - localparam MAX_INPUTS = 16;
  - function rr_next(valid vector, last grant) returning the round-robin winner index.
- Sub-module axis_rr_pick: purely combinational rotate-and-priority-encode, wrapping rr_next. Inputs: valid vector and pointer. Outputs: winner index and any_valid.
- The top level holds the FSM, GRANT register, ready generation, the input mux and the output slice.

## Test plan
- Reset, then TVALID=4'b1111 with one-beat packets on all inputs and M_AXIS_TREADY=1: GRANT sequence 0,1,2,3,0.
- Input 2 sends a 5-beat packet while input 1 asserts TVALID from the second cycle: the 5 beats of input 2 arrive contiguous, then input 3 is skipped (idle) and input 1 is granted next.
- M_AXIS_TREADY held 0 for 3 cycles mid-packet: M_AXIS_TDATA is stable (e.g. 'hA5) and S_AXIS_TREADY[GRANT]=0 throughout; the flow resumes with no duplicated or lost beat.
- Granted input drops TVALID for 2 cycles mid-packet while input 0 is valid: the grant is held, input 0 stays unserved until TLAST.
- RST pulsed while locked on input 3: next cycle M_AXIS_TVALID=0 and the FSM is IDLE; with all inputs valid, the next grant is 0.
- With AXIS_ARB_TID_EN: M_AXIS_TID equals the source index on every output beat; random-stall scoreboard over 1000 packets across 4 inputs shows no interleaving.
